// File: rtl/demux_pkg.sv
// Shared types and helpers for the streaming 1-to-N demultiplexer.
package demux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int STAT_W = 16;

  function automatic logic sel_in_range(input int sel, input int n);
    return (sel >= 0) && (sel < n);
  endfunction

endpackage

// File: rtl/demux_sat_counter.sv
// Saturating up-counter; a synchronous clear takes priority over an increment.
module demux_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N stream demultiplexer with a single-entry holding register.
// Define DEMUX_STATS_EN to add per-channel transfer counters and a drop counter.
module demux_stream_1xn
  import demux_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int W         = 8,
  localparam int SEL_W     = $clog2(N),
  parameter  bit ZERO_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [SEL_W-1:0] in_sel,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [N*W-1:0]   out_data,
  output logic             drop_pulse
`ifdef DEMUX_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [N*STAT_W-1:0]   stat_cnt,
  output logic [STAT_W-1:0]     drop_cnt
`endif
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   hold_sel_q, hold_sel_d;
  logic [W-1:0]       hold_data_q, hold_data_d;
  logic [N-1:0]       valid_q, valid_d;
  logic               drop_q, drop_d;

  logic in_xfer;
  logic out_xfer;
  logic in_ok;

  // valid_q is one-hot or zero, so this picks the ready of the held channel only.
  assign out_xfer = |(valid_q & out_ready);
  assign in_ready = !rst && ((state_q == EMPTY) || out_xfer);
  assign in_xfer  = in_valid && in_ready;
  assign in_ok    = sel_in_range(int'(in_sel), N);

  always_comb begin
    state_d     = state_q;
    hold_sel_d  = hold_sel_q;
    hold_data_d = hold_data_q;
    valid_d     = valid_q;
    drop_d      = in_xfer && !in_ok;

    if (in_xfer && in_ok) begin
      state_d     = FULL;
      hold_sel_d  = in_sel;
      hold_data_d = in_data;
      for (int i = 0; i < N; i++) begin
        valid_d[i] = (in_sel == SEL_W'(i));
      end
    end else if (out_xfer) begin
      state_d = EMPTY;
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      hold_sel_q  <= '0;
      hold_data_q <= '0;
      valid_q     <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_sel_q  <= hold_sel_d;
      hold_data_q <= hold_data_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid  = valid_q;
  assign drop_pulse = drop_q;

  // Data lanes come straight from the holding register; no path from in_data.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign out_data[gi*W +: W] =
      (!ZERO_IDLE || (hold_sel_q == SEL_W'(gi))) ? hold_data_q : '0;
  end

`ifdef DEMUX_STATS_EN
  for (genvar gi = 0; gi < N; gi++) begin : g_stat
    demux_sat_counter #(.WIDTH(STAT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (stat_clr),
      .inc (valid_q[gi] && out_ready[gi]),
      .cnt (stat_cnt[gi*STAT_W +: STAT_W])
    );
  end

  demux_sat_counter #(.WIDTH(STAT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .clr (stat_clr),
    .inc (drop_q),
    .cnt (drop_cnt)
  );
`endif

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Directed-vector bench: a 4-channel instance for routing/backpressure and a
// 3-channel instance for out-of-range selects.
module tb_demux_stream_1xn;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=4 instance
  logic        a_in_valid, a_in_ready;
  logic [7:0]  a_in_data;
  logic [1:0]  a_in_sel;
  logic [3:0]  a_out_valid, a_out_ready;
  logic [31:0] a_out_data;
  logic        a_drop;

  // N=3 instance
  logic        b_in_valid, b_in_ready;
  logic [7:0]  b_in_data;
  logic [1:0]  b_in_sel;
  logic [2:0]  b_out_valid, b_out_ready;
  logic [23:0] b_out_data;
  logic        b_drop;

`ifdef DEMUX_STATS_EN
  logic        stat_clr;
  logic [63:0] a_stat_cnt;
  logic [15:0] a_drop_cnt;
  logic [47:0] b_stat_cnt;
  logic [15:0] b_drop_cnt;
`endif

  demux_stream_1xn #(.N(4), .W(8), .ZERO_IDLE(1'b1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_data    (a_in_data),
    .in_sel     (a_in_sel),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_data   (a_out_data),
    .drop_pulse (a_drop)
`ifdef DEMUX_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_cnt   (a_stat_cnt),
    .drop_cnt   (a_drop_cnt)
`endif
  );

  demux_stream_1xn #(.N(3), .W(8), .ZERO_IDLE(1'b1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_data    (b_in_data),
    .in_sel     (b_in_sel),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_data   (b_out_data),
    .drop_pulse (b_drop)
`ifdef DEMUX_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_cnt   (b_stat_cnt),
    .drop_cnt   (b_drop_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    a_in_valid  = 1'b1;
    a_in_sel    = 2'd0;
    a_in_data   = 8'h55;
    a_out_ready = 4'hF;
    b_in_valid  = 1'b1;
    b_in_sel    = 2'd0;
    b_in_data   = 8'h55;
    b_out_ready = 3'h7;
`ifdef DEMUX_STATS_EN
    stat_clr    = 1'b0;
`endif

    // Reset held for three cycles with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("rst_a_in_ready",  64'(a_in_ready),  64'd0);
      check_eq("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      check_eq("rst_a_out_data",  64'(a_out_data),  64'd0);
      check_eq("rst_a_drop",      64'(a_drop),      64'd0);
      check_eq("rst_b_in_ready",  64'(b_in_ready),  64'd0);
      check_eq("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    end
    rst        = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;

    // Routing: 0xA5 to channel 2
    a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 8'hA5;
    #1 check_eq("route_in_ready", 64'(a_in_ready), 64'd1);
    cyc();
    a_in_valid = 1'b0;
    check_eq("route_out_valid", 64'(a_out_valid), 64'h4);
    check_eq("route_out_data",  64'(a_out_data),  64'h00A5_0000);
    cyc();
    check_eq("route_drained",   64'(a_out_valid), 64'h0);

    // Backpressure: 0x3C to channel 1 while channel 1 is not ready
    a_out_ready = 4'b1101;
    a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_data = 8'h3C;
    cyc();
    a_in_sel = 2'd0; a_in_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_in_ready",  64'(a_in_ready),  64'd0);
      check_eq("bp_out_valid", 64'(a_out_valid), 64'h2);
      check_eq("bp_out_data",  64'(a_out_data),  64'h0000_3C00);
      cyc();
    end
    a_out_ready = 4'hF;
    #1;
    check_eq("bp_release_in_ready",  64'(a_in_ready),  64'd1);
    check_eq("bp_release_out_valid", 64'(a_out_valid), 64'h2);
    cyc();
    a_in_valid = 1'b0;
    check_eq("bp_passthru_valid", 64'(a_out_valid), 64'h1);
    check_eq("bp_passthru_data",  64'(a_out_data),  64'h0000_0077);
    cyc();
    check_eq("bp_drained", 64'(a_out_valid), 64'h0);

    // Back-to-back: 0x01->ch0, 0x02->ch3, 0x03->ch0
    a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 8'h01;
    cyc();
    a_in_sel = 2'd3; a_in_data = 8'h02;
    check_eq("b2b_1_valid", 64'(a_out_valid), 64'h1);
    check_eq("b2b_1_data",  64'(a_out_data),  64'h0000_0001);
    check_eq("b2b_1_ready", 64'(a_in_ready),  64'd1);
    cyc();
    a_in_sel = 2'd0; a_in_data = 8'h03;
    check_eq("b2b_2_valid", 64'(a_out_valid), 64'h8);
    check_eq("b2b_2_data",  64'(a_out_data),  64'h0200_0000);
    check_eq("b2b_2_ready", 64'(a_in_ready),  64'd1);
    cyc();
    a_in_valid = 1'b0;
    check_eq("b2b_3_valid", 64'(a_out_valid), 64'h1);
    check_eq("b2b_3_data",  64'(a_out_data),  64'h0000_0003);
    cyc();
    check_eq("b2b_drained", 64'(a_out_valid), 64'h0);

    // Out of range on N=3 from EMPTY
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'hFF;
    #1 check_eq("oor_in_ready", 64'(b_in_ready), 64'd1);
    cyc();
    b_in_valid = 1'b0;
    check_eq("oor_drop",      64'(b_drop),      64'd1);
    check_eq("oor_out_valid", 64'(b_out_valid), 64'h0);
    cyc();
    check_eq("oor_drop_once", 64'(b_drop),      64'd0);
    check_eq("oor_empty",     64'(b_in_ready),  64'd1);

    // Out of range arriving while FULL with a same-cycle drain
    b_in_valid = 1'b1; b_in_sel = 2'd1; b_in_data = 8'h5A;
    cyc();
    b_in_sel = 2'd3; b_in_data = 8'hEE;
    check_eq("oor_full_valid", 64'(b_out_valid), 64'h2);
    check_eq("oor_full_data",  64'(b_out_data),  64'h00_5A00);
    cyc();
    b_in_valid = 1'b0;
    check_eq("oor_full_drop",  64'(b_drop),      64'd1);
    check_eq("oor_full_empty", 64'(b_out_valid), 64'h0);
    cyc();
    check_eq("oor_full_drop_once", 64'(b_drop), 64'd0);

`ifdef DEMUX_STATS_EN
    check_eq("stat_b_drop_cnt", 64'(b_drop_cnt), 64'd2);
    check_eq("stat_a_drop_cnt", 64'(a_drop_cnt), 64'd0);
    check_eq("stat_a_ch3",      64'(a_stat_cnt[63:48]), 64'd1);
    a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 8'h11;
    repeat (70010) @(posedge clk);
    @(negedge clk);
    check_eq("stat_sat_ch0", 64'(a_stat_cnt[15:0]), 64'hFFFF);
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    check_eq("stat_clr_ch0", 64'(a_stat_cnt[15:0]), 64'd0);
    check_eq("stat_clr_ch3", 64'(a_stat_cnt[63:48]), 64'd0);
    cyc();
    check_eq("stat_after_clr", 64'(a_stat_cnt[15:0]), 64'd1);
    a_in_valid = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
